// File: rtl/mac_pkg.sv
// mac_pkg: shared types and default sizes for the MAC accumulator slice.
package mac_pkg;

   // Frame-control states of the accumulator
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } mac_state_e;

   // Default accumulator / result width (minimum 8)
   localparam int unsigned ACC_W_DEF = 10;
   // Default frame-length input width; frame length range is 1..2^LEN_W
   localparam int unsigned LEN_W_DEF = 4;
   // Width of the incoming product from the 4x4 array multiplier
   localparam int unsigned PROD_W    = 8;

endpackage : mac_pkg

// File: rtl/mac_sat_add.sv
// mac_sat_add: combinational ACC_W + PROD_W unsigned add with carry out.
// Build option MAC_ACC_SAT_EN: when defined, a carry out clamps the sum to
// all-ones; when undefined, the sum wraps modulo 2^ACC_W.
module mac_sat_add
   import mac_pkg::*;
#(
   parameter int unsigned ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0]  acc_i,
   input  logic [PROD_W-1:0] prod_i,
   output logic [ACC_W-1:0]  sum_o,
   output logic              carry_o
);

   logic [ACC_W:0] wide_sum;

   // One-bit-wider add; the top bit is the overflow carry
   always_comb begin
      wide_sum = {1'b0, acc_i} + (ACC_W+1)'(prod_i);
      carry_o  = wide_sum[ACC_W];
`ifdef MAC_ACC_SAT_EN
      // Once clamped, acc stays at all-ones: adding any prod to it either
      // carries again or (prod==0) leaves it unchanged.
      sum_o    = carry_o ? '1 : wide_sum[ACC_W-1:0];
`else
      sum_o    = wide_sum[ACC_W-1:0];
`endif
   end

endmodule : mac_sat_add

// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulates a programmable-length frame of 8-bit products
// into an ACC_W-bit sum and presents it on a held valid/ready result port.
// Build option MAC_ACC_SAT_EN (in mac_sat_add) selects saturating instead of
// wrapping accumulation; out_ovf is sticky per frame in both builds.
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int unsigned ACC_W = ACC_W_DEF,
   parameter int unsigned LEN_W = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic [LEN_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_ovf
);

   // Counter/target hold 1..2^LEN_W, so they need one extra bit
   localparam int unsigned CNT_W = LEN_W + 1;

   mac_state_e       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic             ovf_q, ovf_d;

   logic             beat;
   logic [CNT_W-1:0] len_target;
   logic [CNT_W-1:0] cnt_inc;
   logic [ACC_W-1:0] add_base;
   logic [ACC_W-1:0] add_sum;
   logic             add_carry;

   // Handshake and operand selection; the first beat adds onto zero so the
   // same adder both loads and accumulates
   always_comb begin
      in_ready   = (state_q != ST_HOLD) && !clear;
      beat       = in_valid && in_ready;
      len_target = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
      cnt_inc    = cnt_q + CNT_W'(1);
      add_base   = (state_q == ST_IDLE) ? '0 : acc_q;
   end

   mac_sat_add #(
      .ACC_W(ACC_W)
   ) u_add (
      .acc_i  (add_base),
      .prod_i (prod),
      .sum_o  (add_sum),
      .carry_o(add_carry)
   );

   // Next-state, accumulator, counter and overflow update
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      target_d = target_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         ST_IDLE: begin
            if (beat) begin
               target_d = len_target;
               acc_d    = add_sum;
               cnt_d    = CNT_W'(1);
               ovf_d    = add_carry;
               state_d  = (len_target == CNT_W'(1)) ? ST_HOLD : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (beat) begin
               acc_d = add_sum;
               cnt_d = cnt_inc;
               ovf_d = ovf_q | add_carry;
               if (cnt_inc == target_q) begin
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (clear) begin
         state_d  = ST_IDLE;
         acc_d    = '0;
         cnt_d    = '0;
         target_d = '0;
         ovf_d    = 1'b0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         target_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
         ovf_q    <= ovf_d;
      end
   end

   // Result port driven straight from registers
   always_comb begin
      out_valid = (state_q == ST_HOLD);
      out_sum   = acc_q;
      out_ovf   = ovf_q;
   end

endmodule : mac_accumulator

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed and randomized stimulus for mac_accumulator,
// checked against a frame-level reference model (queue of accepted products).
module tb_mac_accumulator;

   localparam int ACC_W = 10;
   localparam int LEN_W = 4;
   localparam int MAXV  = (1 << ACC_W) - 1;
   localparam int FLEN  = 1 << LEN_W;

   logic             clk = 1'b0;
   logic             rst, clear, in_valid, out_ready;
   logic [LEN_W-1:0] len;
   logic [7:0]       prod;
   logic             in_ready, out_valid, out_ovf;
   logic [ACC_W-1:0] out_sum;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit          m_known  = 1'b0;
   bit          m_hold   = 1'b0;
   bit          m_active = 1'b0;
   bit          m_zero   = 1'b0;
   int          m_target = 0;
   int unsigned m_frame[$];
   int unsigned m_sum    = 0;
   bit          m_ovf    = 1'b0;

   always #5 clk = ~clk;

   mac_accumulator #(
      .ACC_W(ACC_W),
      .LEN_W(LEN_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .len      (len),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .prod     (prod),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_ovf  (out_ovf)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Frame result from plain arithmetic on the accepted products
   task automatic close_frame();
      int unsigned total = 0;
      foreach (m_frame[i]) total += m_frame[i];
      m_ovf = (total > MAXV);
`ifdef MAC_ACC_SAT_EN
      m_sum = m_ovf ? MAXV : total;
`else
      m_sum = total % (MAXV + 1);
`endif
      m_hold   = 1'b1;
      m_active = 1'b0;
   endtask

   // One clock cycle: drive at negedge, check outputs, then advance the model
   task automatic cyc(input bit v, input int p, input int l, input bit rdy,
                      input bit clr, input bit r);
      int lv;
      @(negedge clk);
      rst = r; clear = clr; in_valid = v; out_ready = rdy;
      prod = p[7:0]; len = l[LEN_W-1:0];
      #1;
      if (m_known) begin
         check("in_ready", 32'(in_ready), 32'(!m_hold && !clr));
         check("out_valid", 32'(out_valid), 32'(m_hold));
         if (m_hold) begin
            check("out_sum", 32'(out_sum), m_sum);
            check("out_ovf", 32'(out_ovf), 32'(m_ovf));
         end
         if (m_zero) begin
            check("zero_sum", 32'(out_sum), 0);
            check("zero_ovf", 32'(out_ovf), 0);
         end
      end
      @(posedge clk);
      if (r || clr) begin
         m_hold = 0; m_active = 0; m_frame.delete(); m_zero = 1; m_known = 1;
      end else if (m_hold) begin
         if (rdy) m_hold = 0;
      end else if (v) begin
         if (!m_active) begin
            lv       = l % FLEN;
            m_target = (lv == 0) ? FLEN : lv;
            m_active = 1;
            m_zero   = 0;
            m_frame.delete();
         end
         m_frame.push_back(p & 255);
         if (m_frame.size() == m_target) close_frame();
      end
   endtask

   // Directly after an edge: confirm a result with literal expected values
   task automatic peek_result(input string tag, input int s, input bit o);
      #1;
      check({tag, "_valid"}, 32'(out_valid), 1);
      check({tag, "_sum"}, 32'(out_sum), s);
      check({tag, "_ovf"}, 32'(out_ovf), 32'(o));
   endtask

   initial begin
      int n;
      rst = 1; clear = 0; in_valid = 0; out_ready = 0; prod = '0; len = '0;

      // Reset
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);

      // len=3: 10,20,30 back-to-back
      cyc(1, 10, 3, 1, 0, 0);
      cyc(1, 20, 7, 1, 0, 0);
      cyc(1, 30, 2, 1, 0, 0);
      peek_result("tp1", 60, 0);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);

      // len=5: five beats of 225 overflow the 10-bit accumulator
      for (int i = 0; i < 5; i++) cyc(1, 225, 5, 1, 0, 0);
`ifdef MAC_ACC_SAT_EN
      peek_result("tp2", 1023, 1);
`else
      peek_result("tp2", 101, 1);
`endif
      cyc(0, 0, 0, 1, 0, 0);

      // len=2: 7,8 then backpressure with in_valid held
      cyc(1, 7, 2, 0, 0, 0);
      cyc(1, 8, 2, 0, 0, 0);
      peek_result("tp3", 15, 0);
      for (int i = 0; i < 4; i++) cyc(1, 99, 1, 0, 0, 0);
      cyc(1, 99, 1, 1, 0, 0);
      cyc(1, 99, 1, 1, 0, 0);
      peek_result("tp3b", 99, 0);
      cyc(0, 0, 0, 1, 0, 0);

      // len=0 (16 beats) of prod=1 with random idle gaps
      n = 0;
      for (int i = 0; i < 200 && n < 16; i++) begin
         bit v;
         v = 1'($urandom_range(0, 1));
         cyc(v, 1, 0, 1, 0, 0);
         if (v) n++;
      end
      check("tp4_beats", n, 16);
      peek_result("tp4", 16, 0);
      cyc(0, 0, 0, 1, 0, 0);

      // len=4: two beats, then clear alongside a beat, then a len=1 frame
      cyc(1, 50, 4, 1, 0, 0);
      cyc(1, 60, 4, 1, 0, 0);
      cyc(1, 77, 4, 1, 1, 0);
      cyc(0, 0, 4, 1, 0, 0);
      cyc(1, 7, 1, 1, 0, 0);
      peek_result("tp5", 7, 0);
      cyc(0, 0, 0, 1, 0, 0);

      // rst while HOLD waits on out_ready
      cyc(1, 10, 3, 0, 0, 0);
      cyc(1, 20, 3, 0, 0, 0);
      cyc(1, 30, 3, 0, 0, 0);
      peek_result("tp6", 60, 0);
      cyc(0, 0, 0, 0, 0, 1);
      #1;
      check("tp6_rst_valid", 32'(out_valid), 0);
      check("tp6_rst_sum", 32'(out_sum), 0);
      check("tp6_rst_ovf", 32'(out_ovf), 0);
      check("tp6_rst_ready", 32'(in_ready), 1);

      // Randomized traffic: random len every cycle, gaps, backpressure,
      // occasional clear/rst
      for (int i = 0; i < 1500; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
             int'($urandom_range(0, FLEN - 1)), 1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 149) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_mac_accumulator
